// File: rtl/rv32_wb_regfile_if.sv
// Bus between the EX stage / debug port and the writeback + register file block.
// The slave side is the register file; the master side is the pipeline and debug logic.
interface rv32_wb_regfile_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            stall;
  logic            flush;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] reg_s1;
  logic [XLEN-1:0] reg_s2;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic [31:0]     retired_count;

  modport master (
    output ex_valid, ex_rd, ex_result, stall, flush, rs1_addr, rs2_addr, dbg_addr,
    input  reg_s1, reg_s2, wb_valid, wb_rd, dbg_data, retired_count
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, stall, flush, rs1_addr, rs2_addr, dbg_addr,
    output reg_s1, reg_s2, wb_valid, wb_rd, dbg_data, retired_count
  );
endinterface

// File: rtl/rv32_wb_regfile.sv
// RV32 writeback register plus 32x32 architectural register file with
// WB-to-operand forwarding and a retired-result counter.
module rv32_wb_regfile #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  rv32_wb_regfile_if.slave   bus
);

  logic [XLEN-1:0] regs_q [0:31];
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [31:0]     retired_count_q, retired_count_d;
  logic            capture;
  logic            commit;

  // Stall outranks flush: a stalled stage ignores everything on the EX side.
  assign capture = bus.ex_valid && !bus.stall && !bus.flush;
  assign commit  = wb_valid_q && !bus.stall;

  always_comb begin
    wb_valid_d      = wb_valid_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    retired_count_d = retired_count_q;
    if (!bus.stall) begin
      wb_valid_d = capture;
      if (capture) begin
        wb_rd_d   = bus.ex_rd;
        wb_data_d = bus.ex_result;
      end
    end
    if (commit) begin
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_data_q       <= '0;
      retired_count_q <= 32'd0;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Entry 0 is never written, so x0 stays zero without a special read case in the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit && (wb_rd_q != 5'd0)) begin
      regs_q[wb_rd_q] <= wb_data_q;
    end
  end

  // No forwarding from ex_result: that path would loop back through the ALU.
  always_comb begin
    bus.reg_s1 = regs_q[bus.rs1_addr];
    if (bus.rs1_addr == 5'd0) begin
      bus.reg_s1 = '0;
    end else if (wb_valid_q && (bus.rs1_addr == wb_rd_q)) begin
      bus.reg_s1 = wb_data_q;
    end
  end

  always_comb begin
    bus.reg_s2 = regs_q[bus.rs2_addr];
    if (bus.rs2_addr == 5'd0) begin
      bus.reg_s2 = '0;
    end else if (wb_valid_q && (bus.rs2_addr == wb_rd_q)) begin
      bus.reg_s2 = wb_data_q;
    end
  end

  assign bus.dbg_data      = regs_q[bus.dbg_addr];
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.retired_count = retired_count_q;

endmodule
